// File: rtl/tt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tt_pkg
// Brief    : Shared truth-table definitions: FSM states, default widths and
//            the row-to-ID-bit mapping.
// Revision : 1.0  initial release
// ============================================================================
package tt_pkg;

    localparam int c_n_in = 3;
    localparam int c_tt_w = 2 ** c_n_in;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } tt_state_e;

    // Row 0 lands in the ID's MSB so the hex ID reads like the table top-down.
    function automatic int row_to_bit(input int r, input int tt_w);
        return tt_w - 1 - r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_settle_counter.sv
`default_nettype none
// ============================================================================
// Module   : tt_settle_counter
// Brief    : Loadable down-counter that stops at zero and flags it.
// Revision : 1.0  initial release
// ============================================================================
module tt_settle_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_value,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_value;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/tt_characterizer.sv
`default_nettype none
// ============================================================================
// Module   : tt_characterizer
// Brief    : Sweeps all input rows of a combinational CUT and rebuilds its
//            truth-table ID. Define TT_COMPARE_EN to add expected-ID compare.
// Revision : 1.0  initial release
// ============================================================================
module tt_characterizer
    import tt_pkg::*;
#(
    parameter  int N_IN          = c_n_in,
    parameter  int SETTLE_CYCLES = 4,
    localparam int TT_W          = 2 ** N_IN
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] dut_in,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] table_id
`ifdef TT_COMPARE_EN
    ,
    input  logic [TT_W-1:0] expected_id,
    output logic            match
`endif
);

    localparam logic [N_IN-1:0] c_last_vec = {N_IN{1'b1}};
    localparam logic [7:0]      c_reload   = 8'(SETTLE_CYCLES - 1);

    generate
        if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_settle_range_check
            $error("tt_characterizer: SETTLE_CYCLES must be in 1..255");
        end
    endgenerate

    tt_state_e       r_state;
    logic [N_IN-1:0] r_vec;
    logic [N_IN-1:0] r_dut_in;
    logic [TT_W-1:0] r_shadow;
    logic [TT_W-1:0] r_table_id;
    logic            r_busy;
    logic            r_done;
    logic            w_accept;
    logic            w_cnt_zero;
    logic            w_cnt_load;
    logic [N_IN-1:0] w_bit_idx;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_cnt_load = w_accept ||
                        ((r_state == SETTLE) && w_cnt_zero && (r_vec != c_last_vec));
    assign w_bit_idx  = N_IN'(row_to_bit(int'(r_vec), TT_W));

    tt_settle_counter #(
        .CNT_W (8)
    ) u_settle_counter (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_cnt_load),
        .i_load_value (c_reload),
        .o_zero       (w_cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_vec      <= '0;
            r_dut_in   <= '0;
            r_shadow   <= '0;
            r_table_id <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_dut_in <= '0;
                        r_vec    <= '0;
                        r_shadow <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (w_cnt_zero) begin
                        r_shadow[w_bit_idx] <= dut_out;
                        if (r_vec == c_last_vec) begin
                            r_state <= DONE;
                        end else begin
                            r_vec    <= r_vec + 1'b1;
                            r_dut_in <= r_vec + 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_table_id <= r_shadow;
                    r_done     <= 1'b1;
                    r_busy     <= 1'b0;
                    r_dut_in   <= '0;
                    r_state    <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef TT_COMPARE_EN
    logic [TT_W-1:0] r_expected;
    logic            r_match;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_expected <= '0;
            r_match    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_expected <= expected_id;
            end
            if (r_state == DONE) begin
                r_match <= (r_shadow == r_expected);
            end
        end
    end

    assign match = r_match;
`endif

    assign dut_in   = r_dut_in;
    assign busy     = r_busy;
    assign done     = r_done;
    assign table_id = r_table_id;

endmodule
`default_nettype wire

// File: tb/tb_tt_characterizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tt_characterizer
// Brief    : Directed self-checking bench; DUT A uses SETTLE_CYCLES=4, DUT B 1.
// Revision : 1.0  initial release
// ============================================================================
module tb_tt_characterizer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_a = 1'b0;
    logic       start_b = 1'b0;
    logic [2:0] a_in, b_in;
    logic       a_out, b_out;
    logic       a_busy, b_busy, a_done, b_done;
    logic [7:0] a_id, b_id;
    logic       a_mode = 1'b0;
    logic       b_mode = 1'b0;
    logic       sel = 1'b0;
    logic [7:0] exp_a = 8'h00;
    logic [7:0] exp_b = 8'h00;
    logic       match_a, match_b;
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    // CUT A: high on rows 001/110 (0x42), or odd parity (0x69).
    assign a_out = (a_mode == 1'b0) ? ((a_in == 3'b001) || (a_in == 3'b110)) : ^a_in;
    // CUT B: tied low (0x00), or in3 (0x55).
    assign b_out = (b_mode == 1'b0) ? 1'b0 : b_in[0];

    tt_characterizer #(.N_IN(3), .SETTLE_CYCLES(4)) u_dut_a (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_a),
        .dut_in   (a_in),
        .dut_out  (a_out),
        .busy     (a_busy),
        .done     (a_done),
`ifdef TT_COMPARE_EN
        .expected_id (exp_a),
        .match       (match_a),
`endif
        .table_id (a_id)
    );

    tt_characterizer #(.N_IN(3), .SETTLE_CYCLES(1)) u_dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_b),
        .dut_in   (b_in),
        .dut_out  (b_out),
        .busy     (b_busy),
        .done     (b_done),
`ifdef TT_COMPARE_EN
        .expected_id (exp_b),
        .match       (match_b),
`endif
        .table_id (b_id)
    );

    logic [2:0] obs_in;
    logic       obs_busy, obs_done;
    logic [7:0] obs_id;
    assign obs_in   = sel ? b_in   : a_in;
    assign obs_busy = sel ? b_busy : a_busy;
    assign obs_done = sel ? b_done : a_done;
    assign obs_id   = sel ? b_id   : a_id;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // One full sweep; optionally re-pulses start mid-sweep (repulse_at > 0).
    task automatic sweep(input logic use_b, input int s, input logic [7:0] exp_id,
                         input string tag, input int repulse_at);
        int         first_done;
        int         n_done;
        int         n_bad;
        logic [2:0] exp_in;
        sel = use_b;
        @(negedge clk);
        if (use_b) start_b = 1'b1; else start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        start_b = 1'b0;
        chk({tag, "_busy_on_accept"}, obs_busy, 1);
        first_done = -1;
        n_done = 0;
        n_bad = (obs_in !== 3'd0) ? 1 : 0;
        for (int k = 1; k <= 8 * s + 4; k++) begin
            if (k == repulse_at) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
            end else begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            @(posedge clk);
            #1;
            if (k < 8 * s)       exp_in = 3'(k / s);
            else if (k == 8 * s) exp_in = 3'd7;
            else                 exp_in = 3'd0;
            if (obs_in !== exp_in) n_bad++;
            if (obs_done === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = k;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        chk({tag, "_done_latency"}, first_done, 8 * s + 1);
        chk({tag, "_done_count"}, n_done, 1);
        chk({tag, "_dut_in_seq_errors"}, n_bad, 0);
        chk({tag, "_table_id"}, obs_id, exp_id);
        chk({tag, "_busy_after"}, obs_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_a_dut_in", a_in, 0);
        chk("reset_a_busy", a_busy, 0);
        chk("reset_a_done", a_done, 0);
        chk("reset_a_table_id", a_id, 0);
        chk("reset_b_table_id", b_id, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef TT_COMPARE_EN
        exp_a = 8'h42;
        sweep(1'b0, 4, 8'h42, "a_0x42_cmp", -1);
        chk("match_0x42", match_a, 1);
        exp_a = 8'h43;
        sweep(1'b0, 4, 8'h42, "a_0x43_cmp", -1);
        chk("match_0x43", match_a, 0);
`endif

        a_mode = 1'b0;
        sweep(1'b0, 4, 8'h42, "a_0x42", -1);
        b_mode = 1'b0;
        sweep(1'b1, 1, 8'h00, "b_zero", -1);
        b_mode = 1'b1;
        sweep(1'b1, 1, 8'h55, "b_in3", -1);
        a_mode = 1'b1;
        sweep(1'b0, 4, 8'h69, "a_parity", -1);
        a_mode = 1'b0;
        sweep(1'b0, 4, 8'h42, "a_repulse", 10);
        sweep(1'b0, 4, 8'h42, "a_fresh", -1);

        // Asynchronous reset 15 cycles into a sweep.
        sel = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (15) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_dut_in", a_in, 0);
        chk("midreset_busy", a_busy, 0);
        chk("midreset_table_id", a_id, 0);
        begin
            int n_done_rst = 0;
            for (int k = 0; k < 4; k++) begin
                @(posedge clk);
                #1;
                if (a_done === 1'b1) n_done_rst++;
            end
            @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk);
                #1;
                if (a_done === 1'b1) n_done_rst++;
            end
            chk("midreset_no_done", n_done_rst, 0);
        end
        sweep(1'b0, 4, 8'h42, "a_after_reset", -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
